// File: rtl/pinf_video_pkg.sv
// Raster timing constants and read-FSM state encoding shared by the pinf TX
// FIFO reader and its timing generator.
package pinf_video_pkg;

    function automatic int timing_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    // Counter width able to hold 0..total-1.
    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    localparam int P1080_H_ACTIVE = 1920;
    localparam int P1080_H_FP     = 88;
    localparam int P1080_H_SYNC   = 44;
    localparam int P1080_H_BP     = 148;
    localparam int P1080_V_ACTIVE = 1080;
    localparam int P1080_V_FP     = 4;
    localparam int P1080_V_SYNC   = 5;
    localparam int P1080_V_BP     = 36;

    localparam int P1080_H_TOTAL =
        timing_total(P1080_H_ACTIVE, P1080_H_FP, P1080_H_SYNC, P1080_H_BP);
    localparam int P1080_V_TOTAL =
        timing_total(P1080_V_ACTIVE, P1080_V_FP, P1080_V_SYNC, P1080_V_BP);

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } rd_state_e;

endpackage

// File: rtl/pinf_tx_fifo_reader_if.sv
// Read port of the 32-bit pixel FIFO; master is the consumer issuing ren,
// slave is the FIFO itself.
interface pinf_tx_fifo_reader_if;
    logic [31:0] rdata;
    logic        rempty;
    logic        prog_empty;
    logic        ren;

    modport master (output ren, input rdata, input rempty, input prog_empty);
    modport slave  (input ren, output rdata, output rempty, output prog_empty);
endinterface

// File: rtl/video_timing_gen.sv
// Horizontal/vertical raster counters with active, hsync and vsync decode.
// Counters sit at zero whenever en is low.
module video_timing_gen
    import pinf_video_pkg::*;
#(
    parameter int H_ACTIVE = P1080_H_ACTIVE,
    parameter int H_FP     = P1080_H_FP,
    parameter int H_SYNC   = P1080_H_SYNC,
    parameter int H_BP     = P1080_H_BP,
    parameter int V_ACTIVE = P1080_V_ACTIVE,
    parameter int V_FP     = P1080_V_FP,
    parameter int V_SYNC   = P1080_V_SYNC,
    parameter int V_BP     = P1080_V_BP,
    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int HCNT_W  = cnt_width(H_TOTAL),
    localparam int VCNT_W  = cnt_width(V_TOTAL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [HCNT_W-1:0] hcnt,
    output logic [VCNT_W-1:0] vcnt,
    output logic              act,
    output logic              hs_c,
    output logic              vs_c
);

    localparam logic [HCNT_W-1:0] H_LAST    = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] H_ACT_END = HCNT_W'(H_ACTIVE);
    localparam logic [HCNT_W-1:0] HS_BEGIN  = HCNT_W'(H_ACTIVE + H_FP);
    localparam logic [HCNT_W-1:0] HS_END    = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCNT_W-1:0] V_LAST    = VCNT_W'(V_TOTAL - 1);
    localparam logic [VCNT_W-1:0] V_ACT_END = VCNT_W'(V_ACTIVE);
    localparam logic [VCNT_W-1:0] VS_BEGIN  = VCNT_W'(V_ACTIVE + V_FP);
    localparam logic [VCNT_W-1:0] VS_END    = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    assign act  = (hcnt < H_ACT_END) && (vcnt < V_ACT_END);
    assign hs_c = (hcnt >= HS_BEGIN) && (hcnt < HS_END);
    assign vs_c = (vcnt >= VS_BEGIN) && (vcnt < VS_END);

endmodule

// File: rtl/pinf_tx_fifo_reader.sv
// Pulls packed pixel pairs from the TX FIFO and emits one 16-bit pixel per
// clock with raster timing; primes on prog_empty, then free-runs until reset.
module pinf_tx_fifo_reader
    import pinf_video_pkg::*;
#(
    parameter int H_ACTIVE = P1080_H_ACTIVE,
    parameter int H_FP     = P1080_H_FP,
    parameter int H_SYNC   = P1080_H_SYNC,
    parameter int H_BP     = P1080_H_BP,
    parameter int V_ACTIVE = P1080_V_ACTIVE,
    parameter int V_FP     = P1080_V_FP,
    parameter int V_SYNC   = P1080_V_SYNC,
    parameter int V_BP     = P1080_V_BP
) (
    input  logic                  rclk,
    input  logic                  reset,
    pinf_tx_fifo_reader_if.master fifo,
    output logic [15:0]           pix_data,
    output logic                  pix_de,
    output logic                  pix_hs,
    output logic                  pix_vs,
    output logic                  frame_start,
    output logic                  underflow,
    output logic                  running
);

    localparam int HCNT_W = cnt_width(timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int VCNT_W = cnt_width(timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP));

    rd_state_e         state;
    logic [HCNT_W-1:0] hcnt;
    logic [VCNT_W-1:0] vcnt;
    logic              act;
    logic              hs_c;
    logic              vs_c;

    logic              run_p0;
    logic              pair_p0;
    logic              issue_p0;

    logic              vld_p1;
    logic              hs_p1;
    logic              vs_p1;
    logic              odd_p1;
    logic              starve_p1;
    logic [15:0]       hold_pix_p1;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk  (rclk),
        .rst  (reset),
        .en   (run_p0),
        .hcnt (hcnt),
        .vcnt (vcnt),
        .act  (act),
        .hs_c (hs_c),
        .vs_c (vs_c)
    );

    // ---- stage p0: counter position, read issue ----
    assign run_p0   = (state == RUN);
    assign pair_p0  = run_p0 && act && !hcnt[0];
    assign issue_p0 = pair_p0 && !fifo.rempty;
    assign fifo.ren = issue_p0;

    always_ff @(posedge rclk) begin
        if (reset) begin
            state   <= PRIME;
            running <= 1'b0;
        end else begin
            case (state)
                PRIME: begin
                    if (!fifo.prog_empty) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                end
            endcase
        end
    end

    // ---- stage p1: registered timing/control, one cycle behind the counters ----
    always_ff @(posedge rclk) begin
        if (reset || !run_p0) begin
            vld_p1      <= 1'b0;
            hs_p1       <= 1'b0;
            vs_p1       <= 1'b0;
            odd_p1      <= 1'b0;
            starve_p1   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vld_p1      <= act;
            hs_p1       <= hs_c;
            vs_p1       <= vs_c;
            odd_p1      <= hcnt[0];
            frame_start <= (hcnt == '0) && (vcnt == '0);
            // A starved even slot blanks both pixels of the pair.
            if (pair_p0) begin
                starve_p1 <= fifo.rempty;
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            underflow <= 1'b0;
        end else if (pair_p0 && fifo.rempty) begin
            underflow <= 1'b1;
        end
    end

    always_ff @(posedge rclk) begin
        if (vld_p1 && !odd_p1) begin
            hold_pix_p1 <= fifo.rdata[31:16];
        end
    end

    // rdata is the FIFO's own output register, so the even pixel is taken
    // straight from it in the cycle it becomes valid.
    always_comb begin
        pix_data = '0;
        if (vld_p1 && !starve_p1) begin
            pix_data = odd_p1 ? hold_pix_p1 : fifo.rdata[15:0];
        end
    end

    assign pix_de = vld_p1;
    assign pix_hs = hs_p1;
    assign pix_vs = vs_p1;

endmodule

// File: tb/tb_pinf_tx_fifo_reader.sv
// Bench for pinf_tx_fifo_reader with a small raster (14x5) and a queue-based FIFO.
module tb_pinf_tx_fifo_reader;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 2, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        rclk = 1'b0;
    logic        reset;
    logic [15:0] pix_data;
    logic        pix_de, pix_hs, pix_vs, frame_start, underflow, running;

    pinf_tx_fifo_reader_if fifo_if ();

    pinf_tx_fifo_reader #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .rclk        (rclk),
        .reset       (reset),
        .fifo        (fifo_if),
        .pix_data    (pix_data),
        .pix_de      (pix_de),
        .pix_hs      (pix_hs),
        .pix_vs      (pix_vs),
        .frame_start (frame_start),
        .underflow   (underflow),
        .running     (running)
    );

    always #5 rclk = ~rclk;

    logic [31:0] fifo_q[$];
    logic [31:0] ref_q[$];

    always @(posedge rclk) begin
        if (fifo_if.ren && fifo_q.size() > 0) fifo_if.rdata <= fifo_q.pop_front();
    end

    int checks = 0;
    int errors = 0;

    // Reference model: position in frame counted from the first RUN cycle.
    bit          m_run;
    int          m_pos;
    bit          m_uf;
    logic [31:0] m_pair;
    logic [15:0] e_pix;
    logic        e_de, e_hs, e_vs, e_fs, e_uf, e_run;

    logic        obs_ren, obs_de, obs_hs, obs_vs, obs_fs, obs_uf, obs_run;
    logic [15:0] obs_pix;
    logic [15:0] seen[$];
    logic [HT-1:0] ren_mask;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        ref_q.push_back(w);
    endtask

    // One clock: apply inputs, check at the falling edge, advance the model.
    task automatic step(input logic r, input logic pe, input logic re);
        int h, v;
        logic slot;
        logic [31:0] w;
        while (fifo_q.size() < 4) push_word($urandom);
        reset = r;
        fifo_if.prog_empty = pe;
        fifo_if.rempty = re;
        h = m_pos % HT;
        v = m_pos / HT;
        slot = m_run && (h < HA) && (v < VA) && (h % 2 == 0);
        @(negedge rclk);
        obs_ren = fifo_if.ren; obs_pix = pix_data; obs_de = pix_de; obs_hs = pix_hs;
        obs_vs = pix_vs; obs_fs = frame_start; obs_uf = underflow; obs_run = running;
        chk1("ren", obs_ren, slot && !re);
        chk16("pix_data", obs_pix, e_pix);
        chk1("pix_de", obs_de, e_de);
        chk1("pix_hs", obs_hs, e_hs);
        chk1("pix_vs", obs_vs, e_vs);
        chk1("frame_start", obs_fs, e_fs);
        chk1("underflow", obs_uf, e_uf);
        chk1("running", obs_run, e_run);
        if (obs_de) seen.push_back(obs_pix);
        if (m_run && m_pos < HT && obs_ren) ren_mask[m_pos] = 1'b1;
        @(posedge rclk);
        #1;
        w = '0;
        if (slot && !re) w = ref_q.pop_front();
        if (r) begin
            m_run = 0; m_pos = 0; m_uf = 0;
            e_pix = '0; e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_uf = 0; e_run = 0;
        end else if (!m_run) begin
            e_pix = '0; e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_uf = m_uf;
            e_run = !pe;
            if (!pe) begin
                m_run = 1;
                m_pos = 0;
            end
        end else begin
            e_de  = (h < HA) && (v < VA);
            e_hs  = (h >= HA + HF) && (h < HA + HF + HS);
            e_vs  = (v >= VA + VF) && (v < VA + VF + VS);
            e_fs  = (m_pos == 0);
            e_run = 1;
            if (e_de) begin
                if (h % 2 == 0) begin
                    if (re) begin
                        m_uf = 1;
                        m_pair = '0;
                    end else begin
                        m_pair = w;
                    end
                    e_pix = m_pair[15:0];
                end else begin
                    e_pix = m_pair[31:16];
                end
            end else begin
                e_pix = '0;
            end
            e_uf = m_uf;
            m_pos = (m_pos + 1) % FT;
        end
    endtask

    typedef struct {
        logic rst;
        logic pe;
        logic re;
        int   reps;
        logic ren;
        logic run;
        logic fs;
        logic de;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        int de_cnt, hs_cnt, vs_cnt, vs_first, vs_last, hs_first, de_first, fs_a, fs_b, guard;
        bit found;

        reset = 1'b1;
        fifo_if.prog_empty = 1'b1;
        fifo_if.rempty = 1'b0;
        repeat (3) @(posedge rclk);
        #1;
        m_run = 0; m_pos = 0; m_uf = 0; m_pair = '0;
        e_pix = '0; e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_uf = 0; e_run = 0;
        ren_mask = '0;

        push_word(32'h0002_0001);
        push_word(32'h0004_0003);
        push_word(32'h0006_0005);
        push_word(32'h0008_0007);

        //            rst   pe    re  reps  ren   run   fs    de
        vecs[0] = '{1'b1, 1'b1, 1'b0, 2,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 20, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b1};

        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < vecs[i].reps; k++) begin
                step(vecs[i].rst, vecs[i].pe, vecs[i].re);
                chk1($sformatf("vec%0d ren", i), obs_ren, vecs[i].ren);
                chk1($sformatf("vec%0d running", i), obs_run, vecs[i].run);
                chk1($sformatf("vec%0d frame_start", i), obs_fs, vecs[i].fs);
                chk1($sformatf("vec%0d de", i), obs_de, vecs[i].de);
                chk1($sformatf("vec%0d hs", i), obs_hs, 1'b0);
                chk1($sformatf("vec%0d vs", i), obs_vs, 1'b0);
            end
        end

        // Finish line 0 and verify unpack order and read cadence.
        guard = 0;
        while (m_pos != HT && guard < 40) begin
            step(1'b0, ($urandom % 2) == 1, 1'b0);
            guard++;
        end
        chk1("reach line 1", m_pos == HT, 1'b1);
        chk1("unpack count", seen.size() >= 8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i < seen.size()) chk16($sformatf("unpack pix%0d", i), seen[i], 16'(i + 1));
        end
        chkn("line0 ren pattern", int'(ren_mask), 'h55);

        // One whole frame of timing, starting at the frame origin.
        guard = 0;
        while (m_pos != 0 && guard < 2 * FT) begin
            step(1'b0, 1'b1, 1'b0);
            guard++;
        end
        chk1("reach frame start", m_pos == 0, 1'b1);
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        vs_first = -1; vs_last = -1; hs_first = -1; de_first = -1; fs_a = -1; fs_b = -1;
        for (int j = 0; j <= FT + 1; j++) begin
            step(1'b0, ($urandom % 2) == 1, 1'b0);
            if (obs_fs) begin
                if (fs_a < 0) fs_a = j;
                else if (fs_b < 0) fs_b = j;
            end
            if (j >= 1 && j <= FT) begin
                if (obs_de) begin
                    de_cnt++;
                    if (de_first < 0) de_first = j;
                end
                if (obs_hs) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = j;
                end
                if (obs_vs) begin
                    vs_cnt++;
                    if (vs_first < 0) vs_first = j;
                    vs_last = j;
                end
            end
        end
        chkn("frame de cycles", de_cnt, 16);
        chkn("frame hs cycles", hs_cnt, 2 * VT);
        chkn("hs offset from line start", hs_first - de_first, HA + HF);
        chkn("frame vs cycles", vs_cnt, HT);
        chkn("vs contiguous span", vs_last - vs_first + 1, HT);
        chkn("frame_start period", fs_b - fs_a, FT);

        // Starve the third read of line 0.
        guard = 0;
        while (m_pos != 4 && guard < 2 * FT) begin
            step(1'b0, 1'b1, 1'b0);
            guard++;
        end
        chk1("reach third read", m_pos == 4, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk1("starved slot ren", obs_ren, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk1("starved pix5 de", obs_de, 1'b1);
        chk16("starved pix5 data", obs_pix, 16'h0000);
        step(1'b0, 1'b1, 1'b0);
        chk1("starved pix6 de", obs_de, 1'b1);
        chk16("starved pix6 data", obs_pix, 16'h0000);
        chk1("underflow set", obs_uf, 1'b1);

        // Randomized run: rempty and prog_empty toggle freely.
        for (int i = 0; i < 250; i++) begin
            step(1'b0, ($urandom % 2) == 1, ($urandom % 6) == 0);
        end
        chk1("underflow sticky", obs_uf, 1'b1);

        // Reset at line 1, pixel 3.
        guard = 0;
        while (m_pos != HT + 3 && guard < 2 * FT) begin
            step(1'b0, 1'b1, 1'b0);
            guard++;
        end
        chk1("reach line1 pix3", m_pos == HT + 3, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk1("post-reset running", obs_run, 1'b0);
        chk1("post-reset de", obs_de, 1'b0);
        chk16("post-reset pix", obs_pix, 16'h0000);
        chk1("post-reset hs", obs_hs, 1'b0);
        chk1("post-reset vs", obs_vs, 1'b0);
        chk1("post-reset frame_start", obs_fs, 1'b0);
        chk1("post-reset underflow", obs_uf, 1'b0);
        chk1("post-reset ren", obs_ren, 1'b0);
        repeat (10) step(1'b0, 1'b1, 1'b0);
        chk1("idle running", obs_run, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        found = 0;
        guard = 0;
        while (!found && guard < 6) begin
            step(1'b0, 1'b1, 1'b0);
            if (obs_fs) found = 1;
            guard++;
        end
        chk1("fresh frame_start", found, 1'b1);
        repeat (20) step(1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
